div_mersenne_stream: RTL and testbench
======================================

Name: div_mersenne_stream

Overview:
- Multi-cycle streaming divider: Q = floor(X / D) with D = 2^K - 1, for an N-bit unsigned dividend X.
- X arrives in W-bit beats, MSB beat first, over a valid/ready handshake.
- Quotient is computed by an iterative shift-add loop followed by exact correction, then streamed out in W-bit beats.
- Generalises the fixed 32-bit / divide-by-255 / flag-sequenced datapath: parametrised width, beat width and divisor, plus real flow control.

Parameters:
- N, 32, dividend/quotient width; N % W == 0 required.
- W, 16, beat width of in_data/out_data.
- K, 8, divisor exponent, D = 2^K - 1; 2 <= K < N.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  in_data beat valid
- in_ready  output  1  block can accept a beat
- in_data  input  W  dividend beat, MSB beat first
- out_valid  output  1  out_data beat valid
- out_ready  input  1  sink accepts beat
- out_data  output  W  result beat, MSB beat first
- out_last  output  1  marks final beat of a result
- busy  output  1  high in every state except LOAD

Behaviour:
- Derived values:
  - B = N/W (beats per operand).
  - ITER = ceil(N/K).
  - X1 = X + 1, held at N+1 bits.
  - Internal accumulator t is N+1 bits.
  - Remainder r is signed, N+K+2 bits.
- Reset (clk edge with rst=1), from any state including mid-transfer:
  - state goes to LOAD; beat counters = 0.
  - in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0.
  - A partially loaded X is discarded.
- LOAD:
  - in_ready=1.
  - A beat transfers when in_valid && in_ready; it is shifted into X from the LSB side, so the first beat ends in X[N-1:N-W].
  - After the B-th transfer: in_ready drops the next cycle, X1 and t = X1 are latched, and state goes to ITER.
- ITER:
  - One step per cycle: t <= (t >> K) + X1.
  - Runs exactly ITER-1 cycles; if ITER == 1, it is skipped and LOAD goes straight to QEST.
- QEST, 1 cycle:
  - q <= t >> K, truncated to N bits.
  - r <= X - (q << K) + q, i.e. X - q*D.
- CORR, one adjustment per cycle:
  - if r < 0: q <= q-1, r <= r+D.
  - else if r >= D: q <= q+1, r <= r-D.
  - else: go to SEND.
  - Must complete in at most 3 cycles for all X; the bench flags a violation.
- SEND:
  - Emits B quotient beats, MSB first; out_valid=1 throughout.
  - out_data and out_last are registered and held stable while out_valid && !out_ready.
  - A beat advances only on out_valid && out_ready.
  - out_last=1 on the final beat only.
  - After the final transfer: out_valid=0 the next cycle, state returns to LOAD, in_ready=1.
- Result is exact: Q = floor(X/D) for every X in [0, 2^N - 1]. In particular X+1 ≡ 0 mod D (e.g. X = D-1) must give Q = X/D rounded down, not Q+1.
- No new operand is accepted while busy; in_valid during busy is ignored, with no error.
- Latency, last input beat to first out_valid: (ITER-1) + 1 + (corr cycles) + 1 cycles.

Optional Feature:
- Macro: DIVM_REM_OUT_EN.
- Defined: after the B quotient beats, SEND emits B further beats carrying the remainder r (N bits, zero-extended), MSB first. out_last is asserted on the final remainder beat only, so a result is 2B beats.
- Undefined: only the B quotient beats are sent and out_last is on the last quotient beat. The remainder register is still used internally for correction but is never output.

Test Plan (N=32, W=16, K=8, D=255 unless noted):
- X=0x00000000 -> beats 0x0000, 0x0000 (last); with REM_EN, 2 further beats 0x0000, 0x0000.
- X=0x000000FE (X+1 divisible by D) -> Q beats 0x0000, 0x0000; REM_EN remainder 0x0000, 0x00FE; correction takes <= 3 cycles.
- X=0xFFFFFFFF -> 0x0101, 0x0101; remainder 0. X=0x12345678 -> 0x0012, 0x469D; remainder 0x0000, 0x0015.
- Backpressure: hold out_ready=0 for 5 cycles on the first beat -> out_data stays 0x0012 and out_valid stays 1; no beat is lost or duplicated. in_valid held high during busy -> no operand accepted.
- rst pulsed during ITER, and again after 1 of 2 input beats -> next cycle in_ready=1, out_valid=0; the following fresh X=0x000000FF yields 0x0000, 0x0001.
- N=16, W=8, K=4 (D=15), X=0xFFFF -> 0x11, 0x11; randomized 1000 X vs golden floor(X/15).

Source files
------------

// File: rtl/div_mersenne_stream_if.sv
// Beat-level stream interface for div_mersenne_stream: dividend beats in, result beats out.
// master drives operands and accepts results; slave is the divider.
interface div_mersenne_stream_if #(
  parameter int unsigned W = 16
) ();
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/div_mersenne_stream.sv
// Streaming divider Q = floor(X / (2^K - 1)) via shift-add estimate plus exact correction.
// Define DIVM_REM_OUT_EN to also stream out the N-bit remainder after the quotient.
module div_mersenne_stream #(
  parameter int unsigned N = 32,
  parameter int unsigned W = 16,
  parameter int unsigned K = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  div_mersenne_stream_if.slave io,
  output logic                 busy
);
  localparam int unsigned B     = N / W;
  localparam int unsigned ITERS = (N + K - 1) / K;
  localparam int unsigned ILAST = (ITERS > 1) ? ITERS - 2 : 0;
  localparam int unsigned RW    = N + K + 2;
`ifdef DIVM_REM_OUT_EN
  localparam int unsigned NB    = 2 * B;
`else
  localparam int unsigned NB    = B;
`endif
  localparam int unsigned OLAST = (NB > 1) ? NB - 2 : 0;
  localparam int unsigned OW    = NB * W;
  localparam int unsigned CW    = $clog2(NB + 1);
  localparam int unsigned IW    = $clog2(ITERS + 1);
  localparam logic [RW-1:0] DV  = {{(RW - K){1'b0}}, {K{1'b1}}};

  localparam logic [2:0] StLoad = 3'd0;
  localparam logic [2:0] StIter = 3'd1;
  localparam logic [2:0] StQest = 3'd2;
  localparam logic [2:0] StCorr = 3'd3;
  localparam logic [2:0] StSend = 3'd4;

  logic [2:0]    state_q;
  logic [CW-1:0] in_cnt_q;
  logic [CW-1:0] out_cnt_q;
  logic [IW-1:0] iter_cnt_q;
  logic [N-1:0]  x_q;
  logic [N:0]    x1_q;
  logic [N:0]    t_q;
  logic [N-1:0]  q_q;
  logic [RW-1:0] r_q;  // two's complement, sign in MSB
  logic [OW-1:0] out_sh_q;
  logic          out_last_q;

  logic [N-1:0]  x_next;
  logic [N:0]    x1_next;
  logic [N-1:0]  q_est;
  logic [RW-1:0] r_est;
  logic [OW-1:0] out_load;
  logic          in_fire;
  logic          out_fire;

  always_comb begin
    x_next  = (x_q << W) | N'(io.in_data);
    x1_next = {1'b0, x_next} + (N + 1)'(1);
    q_est   = N'(t_q >> K);
    r_est   = RW'(x_q) - (RW'(q_est) << K) + RW'(q_est);
`ifdef DIVM_REM_OUT_EN
    out_load = {q_q, r_q[N-1:0]};
`else
    out_load = q_q;
`endif
    in_fire  = io.in_valid && (state_q == StLoad);
    out_fire = io.out_ready && (state_q == StSend);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StLoad;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      iter_cnt_q <= '0;
      out_sh_q   <= '0;
      out_last_q <= 1'b0;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (in_fire) begin
            x_q <= x_next;
            if (in_cnt_q == CW'(B - 1)) begin
              in_cnt_q   <= '0;
              x1_q       <= x1_next;
              t_q        <= x1_next;
              iter_cnt_q <= '0;
              state_q    <= (ITERS > 1) ? StIter : StQest;
            end else begin
              in_cnt_q <= in_cnt_q + CW'(1);
            end
          end
        end
        StIter: begin
          // t converges to X1 * 2^K / D; its top N bits estimate the quotient
          t_q        <= (t_q >> K) + x1_q;
          iter_cnt_q <= iter_cnt_q + IW'(1);
          if (iter_cnt_q == IW'(ILAST)) state_q <= StQest;
        end
        StQest: begin
          q_q     <= q_est;
          r_q     <= r_est;
          state_q <= StCorr;
        end
        StCorr: begin
          if (r_q[RW-1]) begin
            q_q <= q_q - N'(1);
            r_q <= r_q + DV;
          end else if (r_q >= DV) begin
            q_q <= q_q + N'(1);
            r_q <= r_q - DV;
          end else begin
            out_sh_q   <= out_load;
            out_cnt_q  <= '0;
            out_last_q <= (NB == 1);
            state_q    <= StSend;
          end
        end
        StSend: begin
          if (out_fire) begin
            if (out_last_q) begin
              out_last_q <= 1'b0;
              state_q    <= StLoad;
            end else begin
              out_sh_q   <= out_sh_q << W;
              out_cnt_q  <= out_cnt_q + CW'(1);
              out_last_q <= (out_cnt_q == CW'(OLAST));
            end
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

  assign io.in_ready  = (state_q == StLoad);
  assign io.out_valid = (state_q == StSend);
  assign io.out_data  = out_sh_q[OW-1 -: W];
  assign io.out_last  = out_last_q;
  assign busy         = (state_q != StLoad);
endmodule

// File: tb/tb_div_mersenne_stream.sv
// Bench for div_mersenne_stream: a 32/16/8 instance with directed cases and a 16/8/4 instance
// with random operands, both checked beat by beat against plain-division expectations.
module tb_div_mersenne_stream;
  localparam int unsigned NA = 32, WA = 16, KA = 8, BA = NA / WA;
  localparam int unsigned NB = 16, WB = 8, KB = 4, BB = NB / WB;
  localparam int unsigned DA = (1 << KA) - 1;
  localparam int unsigned DB = (1 << KB) - 1;
`ifdef DIVM_REM_OUT_EN
  localparam bit REM = 1'b1;
`else
  localparam bit REM = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic busy_a, busy_b;
  bit   rand_ready_b = 1'b0;
  always #5 clk = ~clk;

  div_mersenne_stream_if #(.W(WA)) bus_a ();
  div_mersenne_stream_if #(.W(WB)) bus_b ();

  div_mersenne_stream #(.N(NA), .W(WA), .K(KA)) dut_a (
    .clk(clk), .rst(rst), .io(bus_a), .busy(busy_a)
  );
  div_mersenne_stream #(.N(NB), .W(WB), .K(KB)) dut_b (
    .clk(clk), .rst(rst), .io(bus_b), .busy(busy_b)
  );

  int total = 0;
  int bad   = 0;

  logic [WA-1:0] exp_a[$];
  bit            exp_la[$];
  logic [WA-1:0] got_a[$];
  logic [WB-1:0] exp_b[$];
  bit            exp_lb[$];
  logic [WB-1:0] got_b[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected beat stream: quotient then (optionally) remainder, by plain division.
  function automatic void push_a(input logic [NA-1:0] x);
    logic [2*NA-1:0] w;
    int nb;
    w  = {x / NA'(DA), x % NA'(DA)};
    nb = REM ? 2 * BA : BA;
    for (int i = 0; i < nb; i++) begin
      exp_a.push_back(w[2*NA-1-i*WA -: WA]);
      exp_la.push_back(i == nb - 1);
    end
  endfunction

  function automatic void push_b(input logic [NB-1:0] x);
    logic [2*NB-1:0] w;
    int nb;
    w  = {x / NB'(DB), x % NB'(DB)};
    nb = REM ? 2 * BB : BB;
    for (int i = 0; i < nb; i++) begin
      exp_b.push_back(w[2*NB-1-i*WB -: WB]);
      exp_lb.push_back(i == nb - 1);
    end
  endfunction

  // Compare process: every cycle with out_valid, data and last must match the model front.
  always @(negedge clk) begin
    if (!rst && bus_a.out_valid) begin
      check("a_pending", exp_a.size() > 0, 1);
      if (exp_a.size() > 0) begin
        check("a_data", bus_a.out_data, exp_a[0]);
        check("a_last", bus_a.out_last, exp_la[0]);
        if (bus_a.out_ready) begin
          got_a.push_back(bus_a.out_data);
          void'(exp_a.pop_front());
          void'(exp_la.pop_front());
        end
      end
    end
    if (!rst && bus_b.out_valid) begin
      check("b_pending", exp_b.size() > 0, 1);
      if (exp_b.size() > 0) begin
        check("b_data", bus_b.out_data, exp_b[0]);
        check("b_last", bus_b.out_last, exp_lb[0]);
        if (bus_b.out_ready) begin
          got_b.push_back(bus_b.out_data);
          void'(exp_b.pop_front());
          void'(exp_lb.pop_front());
        end
      end
    end
  end

  task automatic put_a(input logic [WA-1:0] d);
    int n = 0;
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = d;
    @(negedge clk);
    while (!bus_a.in_ready && n < 300) begin n++; @(negedge clk); end
    check("a_in_ready_wait", bus_a.in_ready, 1);
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
  endtask

  task automatic put_b(input logic [WB-1:0] d);
    int n = 0;
    bus_b.in_valid = 1'b1;
    bus_b.in_data  = d;
    @(negedge clk);
    while (!bus_b.in_ready && n < 300) begin n++; @(negedge clk); end
    check("b_in_ready_wait", bus_b.in_ready, 1);
    @(posedge clk); #1;
    bus_b.in_valid = 1'b0;
  endtask

  task automatic send_a(input logic [NA-1:0] x);
    for (int i = BA - 1; i >= 0; i--) put_a(x[i*WA +: WA]);
    push_a(x);
  endtask

  task automatic send_b(input logic [NB-1:0] x);
    for (int i = BB - 1; i >= 0; i--) put_b(x[i*WB +: WB]);
    push_b(x);
  endtask

  // Cycles from the last input beat's edge until out_valid is seen.
  task automatic latency_a(output int n);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!bus_a.out_valid && n < 100);
  endtask

  task automatic drain_a();
    int n = 0;
    while (exp_a.size() != 0 && n < 300) begin @(posedge clk); n++; end
    check("a_drain", exp_a.size(), 0);
    #1;
    check("a_idle_out_valid", bus_a.out_valid, 0);
    check("a_idle_in_ready", bus_a.in_ready, 1);
  endtask

  task automatic drain_b();
    int n = 0;
    while (exp_b.size() != 0 && n < 600) begin @(posedge clk); n++; end
    check("b_drain", exp_b.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic expect_a(input string name, input logic [NA-1:0] q, input logic [NA-1:0] r);
    logic [2*NA-1:0] w;
    int nb;
    w  = {q, r};
    nb = REM ? 2 * BA : BA;
    check({name, "_count"}, got_a.size(), nb);
    for (int i = 0; i < nb && i < got_a.size(); i++) check(name, got_a[i], w[2*NA-1-i*WA -: WA]);
    got_a.delete();
  endtask

  task automatic check_idle_a(input string name);
    check({name, "_in_ready"}, bus_a.in_ready, 1);
    check({name, "_out_valid"}, bus_a.out_valid, 0);
    check({name, "_busy"}, busy_a, 0);
    check({name, "_out_last"}, bus_a.out_last, 0);
    check({name, "_out_data"}, bus_a.out_data, 0);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      bus_b.out_ready = rand_ready_b ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0t expected < 2000000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b1;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_idle_a("reset");

    send_a(32'h0000_0000);
    latency_a(lat);
    check("a_latency_zero", lat, 5);
    drain_a();
    expect_a("x_zero", 32'h0, 32'h0);

    send_a(32'h0000_00FE);
    latency_a(lat);
    check("a_latency_fe", lat, 5);
    drain_a();
    expect_a("x_fe", 32'h0, 32'hFE);

    send_a(32'hFFFF_FFFF);
    latency_a(lat);
    check("a_corr_bound_ffffffff", (lat >= 5) && (lat <= 8), 1);
    drain_a();
    expect_a("x_ffffffff", 32'h0101_0101, 32'h0);

    // Backpressure on the first beat while in_valid is held during busy.
    bus_a.out_ready = 1'b0;
    send_a(32'h1234_5678);
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 16'hAAAA;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
      check("a_busy_no_accept", bus_a.in_ready, 0);
    end while (!bus_a.out_valid && lat < 100);
    check("a_corr_bound_12345678", (lat >= 5) && (lat <= 8), 1);
    bus_a.in_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      check("a_hold_valid", bus_a.out_valid, 1);
      check("a_hold_data", bus_a.out_data, 16'h0012);
    end
    bus_a.out_ready = 1'b1;
    drain_a();
    expect_a("x_12345678", 32'h0012_469D, 32'h15);
    repeat (10) @(posedge clk);
    #1 check("a_no_extra_operand", busy_a, 0);

    // Reset during ITER, then reset after one of two input beats.
    send_a(32'hDEAD_BEEF);
    exp_a.delete(); exp_la.delete();
    @(posedge clk); #1;
    pulse_rst();
    check_idle_a("rst_iter");
    put_a(16'h1234);
    pulse_rst();
    check_idle_a("rst_partial");
    send_a(32'h0000_00FF);
    drain_a();
    expect_a("x_ff", 32'h1, 32'h0);

    // Small instance: pinned corner then random operands under random backpressure.
    send_b(16'hFFFF);
    drain_b();
    check("b_ffff_count", got_b.size(), REM ? 4 : 2);
    if (got_b.size() >= 2) begin
      check("b_ffff_hi", got_b[0], 8'h11);
      check("b_ffff_lo", got_b[1], 8'h11);
    end
    got_b.delete();
    send_b(16'd14);
    send_b(16'd15);
    rand_ready_b = 1'b1;
    for (int i = 0; i < 1000; i++) send_b(16'($urandom_range(0, 65535)));
    drain_b();
    rand_ready_b = 1'b0;
    drain_b();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
